demux_destino: RTL and testbench

//  Write-side companion to the roundRobin arbiter. Pops 10-bit words from one

---
 rtl/demux_destino.sv | 129 ++++++++++++
 tb/tb_demux_destino.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_destino.sv
// Routes words popped from one upstream FIFO to four destination FIFOs by the top 2 bits.
// Optional per-destination push counters when DEMUX_STATS_EN is defined.
module demux_destino #(
   parameter int unsigned DATA_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  empty_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  pop_in,
   input  logic                  almost_full_F0,
   input  logic                  almost_full_F1,
   input  logic                  almost_full_F2,
   input  logic                  almost_full_F3,
   output logic                  push_F0,
   output logic                  push_F1,
   output logic                  push_F2,
   output logic                  push_F3,
   output logic [DATA_WIDTH-1:0] out_FIFO_0,
   output logic [DATA_WIDTH-1:0] out_FIFO_1,
   output logic [DATA_WIDTH-1:0] out_FIFO_2,
   output logic [DATA_WIDTH-1:0] out_FIFO_3
`ifdef DEMUX_STATS_EN
   ,
   output logic [7:0]            cnt_F0,
   output logic [7:0]            cnt_F1,
   output logic [7:0]            cnt_F2,
   output logic [7:0]            cnt_F3
`endif
);

   typedef enum logic [1:0] {StIdle, StPop, StWait, StPush} state_e;

   state_e                state_q, state_d;
   logic                  pop_q, pop_d;
   logic [3:0]            push_q, push_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [1:0]            dest_q, dest_d;
   logic [DATA_WIDTH-1:0] out_q [4];
   logic [3:0]            af;

   assign af = {almost_full_F3, almost_full_F2, almost_full_F1, almost_full_F0};

   // pop_d/push_d are the values the output registers take next cycle.
   always_comb begin
      state_d = state_q;
      pop_d   = 1'b0;
      push_d  = 4'b0000;
      hold_d  = hold_q;
      dest_d  = dest_q;
      unique case (state_q)
         StIdle: begin
            if (!empty_in) begin
               state_d = StPop;
               pop_d   = 1'b1;
            end
         end
         StPop: state_d = StWait;
         StWait: begin
            hold_d  = data_in;
            dest_d  = data_in[DATA_WIDTH-1 -: 2];
            state_d = StPush;
         end
         StPush: begin
            // Head-of-line stall: only the selected FIFO's almost_full matters.
            if (!af[dest_q]) begin
               push_d[dest_q] = 1'b1;
               if (!empty_in) begin
                  state_d = StPop;
                  pop_d   = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         pop_q   <= 1'b0;
         push_q  <= 4'b0000;
         hold_q  <= '0;
         dest_q  <= 2'd0;
         for (int i = 0; i < 4; i++) out_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pop_q   <= pop_d;
         push_q  <= push_d;
         hold_q  <= hold_d;
         dest_q  <= dest_d;
         for (int i = 0; i < 4; i++) begin
            if (push_d[i]) out_q[i] <= hold_q;
         end
      end
   end

   assign pop_in     = pop_q;
   assign push_F0    = push_q[0];
   assign push_F1    = push_q[1];
   assign push_F2    = push_q[2];
   assign push_F3    = push_q[3];
   assign out_FIFO_0 = out_q[0];
   assign out_FIFO_1 = out_q[1];
   assign out_FIFO_2 = out_q[2];
   assign out_FIFO_3 = out_q[3];

`ifdef DEMUX_STATS_EN
   logic [7:0] cnt_q [4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (push_d[i]) cnt_q[i] <= cnt_q[i] + 8'd1;
         end
      end
   end

   assign cnt_F0 = cnt_q[0];
   assign cnt_F1 = cnt_q[1];
   assign cnt_F2 = cnt_q[2];
   assign cnt_F3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_destino.sv
// Self-checking bench for demux_destino: upstream FIFO model, push monitor and a
// scoreboard of expected words; stats checks run when DEMUX_STATS_EN is defined.
module tb_demux_destino;
   localparam int unsigned W = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         empty_in;
   logic [W-1:0] data_in;
   logic         pop_in;
   logic         af0, af1, af2, af3;
   logic         push0, push1, push2, push3;
   logic [W-1:0] out0, out1, out2, out3;
`ifdef DEMUX_STATS_EN
   logic [7:0]   cnt0, cnt1, cnt2, cnt3;
`endif

   demux_destino #(.DATA_WIDTH(W)) dut (
      .clk            (clk),
      .reset          (reset),
      .empty_in       (empty_in),
      .data_in        (data_in),
      .pop_in         (pop_in),
      .almost_full_F0 (af0),
      .almost_full_F1 (af1),
      .almost_full_F2 (af2),
      .almost_full_F3 (af3),
      .push_F0        (push0),
      .push_F1        (push1),
      .push_F2        (push2),
      .push_F3        (push3),
      .out_FIFO_0     (out0),
      .out_FIFO_1     (out1),
      .out_FIFO_2     (out2),
      .out_FIFO_3     (out3)
`ifdef DEMUX_STATS_EN
      ,
      .cnt_F0         (cnt0),
      .cnt_F1         (cnt1),
      .cnt_F2         (cnt2),
      .cnt_F3         (cnt3)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   vec;
      logic [W-1:0] data;
      int           cyc;
   } obs_t;

   logic [W-1:0] src_q[$];
   logic [W-1:0] exp_q[$];
   obs_t         obs_q[$];
   int           pop_cyc[$];
   int           cyc = 0;
   int           total = 0;
   int           bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Upstream FIFO: read data appears the half-cycle after the pop is seen.
   initial begin
      empty_in = 1'b1;
      data_in  = '0;
      forever begin
         @(negedge clk);
         if (pop_in && src_q.size() > 0) data_in = src_q.pop_front();
         empty_in = (src_q.size() == 0);
      end
   end

   initial begin
      obs_t o;
      logic [3:0] vec;
      forever begin
         @(negedge clk);
         vec = {push3, push2, push1, push0};
         if (pop_in) pop_cyc.push_back(cyc);
         if (vec != 4'b0000) begin
            o.vec  = vec;
            o.data = vec[0] ? out0 : vec[1] ? out1 : vec[2] ? out2 : out3;
            o.cyc  = cyc;
            obs_q.push_back(o);
         end
      end
   end

   task automatic send(input logic [W-1:0] w);
      src_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic wait_obs(input int n, input int bound);
      for (int k = 0; k < bound && obs_q.size() < n; k++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      obs_q.delete();
      pop_cyc.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      af0 = 1'b0; af1 = 1'b0; af2 = 1'b0; af3 = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({pop_in, push3, push2, push1, push0} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 00000", {pop_in, push3, push2, push1, push0});
      end
      reset = 1'b0;
      clear_logs();
      repeat (6) @(negedge clk);
      #1;
      total++;
      if (pop_cyc.size() != 0 || obs_q.size() != 0) begin
         bad++;
         $display("FAIL reset_idle: pops=%0d pushes=%0d want 0/0", pop_cyc.size(), obs_q.size());
      end
      total++;
      if ({out3, out2, out1, out0} !== '0) begin
         bad++;
         $display("FAIL reset_outs: got %h %h %h %h want 0", out0, out1, out2, out3);
      end
   endtask

   task automatic test_single();
      obs_t o;
      logic [W-1:0] e;
      clear_logs();
      send(10'b10_0000_0101);
      wait_obs(1, 20);
      total++;
      if (obs_q.size() < 1 || pop_cyc.size() < 1) begin
         bad++;
         $display("FAIL single_timeout: pushes=%0d pops=%0d want 1/1", obs_q.size(),
                  pop_cyc.size());
         return;
      end
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o.vec !== 4'b0100 || o.data !== 10'h205 || o.data !== e) begin
         bad++;
         $display("FAIL single_push: vec=%b data=%h want 0100/%h", o.vec, o.data, e);
      end
      total++;
      if (o.cyc - pop_cyc[0] != 3) begin
         bad++;
         $display("FAIL single_latency: got %0d want 3", o.cyc - pop_cyc[0]);
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      logic [W-1:0] e;
      int prev;
      clear_logs();
      for (int i = 0; i < 4; i++) send({i[1:0], 8'($urandom_range(0, 255))});
      wait_obs(4, 40);
      total++;
      if (obs_q.size() < 4) begin
         bad++;
         $display("FAIL b2b_timeout: pushes=%0d want 4", obs_q.size());
         return;
      end
      prev = pop_cyc[0];
      for (int i = 0; i < 4; i++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         total++;
         if (o.vec !== (4'b0001 << e[W-1 -: 2]) || o.data !== e) begin
            bad++;
            $display("FAIL b2b_word%0d: vec=%b data=%h want %b/%h", i, o.vec, o.data,
                     4'b0001 << e[W-1 -: 2], e);
         end
         total++;
         if (o.cyc - prev != 3) begin
            bad++;
            $display("FAIL b2b_gap%0d: got %0d want 3", i, o.cyc - prev);
         end
         prev = o.cyc;
      end
   endtask

   task automatic test_stall();
      obs_t o;
      int c;
      clear_logs();
      af0 = 1'b1;
      af1 = 1'b1;
      send(10'b01_1010_0011);
      send(10'b10_0101_1100);
      for (int k = 0; k < 20 && pop_cyc.size() < 1; k++) begin
         @(negedge clk);
         #1;
      end
      repeat (6) @(negedge clk);
      #1;
      total++;
      if (obs_q.size() != 0 || pop_cyc.size() != 1) begin
         bad++;
         $display("FAIL stall_hold: pushes=%0d pops=%0d want 0/1", obs_q.size(), pop_cyc.size());
      end
      af1 = 1'b0;
      c = cyc;
      wait_obs(2, 20);
      total++;
      if (obs_q.size() < 2) begin
         bad++;
         $display("FAIL stall_timeout: pushes=%0d want 2", obs_q.size());
         af0 = 1'b0;
         return;
      end
      o = obs_q.pop_front();
      total++;
      if (o.vec !== 4'b0010 || o.data !== exp_q.pop_front() || o.cyc != c + 1) begin
         bad++;
         $display("FAIL stall_release: vec=%b data=%h cyc=%0d want 0010/1a3/%0d", o.vec, o.data,
                  o.cyc, c + 1);
      end
      o = obs_q.pop_front();
      total++;
      if (o.vec !== 4'b0100 || o.data !== exp_q.pop_front() || o.cyc != c + 4) begin
         bad++;
         $display("FAIL stall_next: vec=%b data=%h cyc=%0d want 0100/25c/%0d", o.vec, o.data,
                  o.cyc, c + 4);
      end
      af0 = 1'b0;
   endtask

   task automatic test_reset_mid();
      obs_t o;
      clear_logs();
      src_q.push_back(10'h3ab);
      for (int k = 0; k < 20 && pop_cyc.size() < 1; k++) begin
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      total++;
      if ({pop_in, push3, push2, push1, push0} !== 5'b0 || {out3, out2, out1, out0} !== '0) begin
         bad++;
         $display("FAIL rstmid_async: ctrl=%b outs=%h %h %h %h want all 0",
                  {pop_in, push3, push2, push1, push0}, out0, out1, out2, out3);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_logs();
      repeat (8) @(negedge clk);
      #1;
      total++;
      if (obs_q.size() != 0) begin
         bad++;
         $display("FAIL rstmid_dropped: pushes=%0d want 0", obs_q.size());
      end
      send(10'h0cd);
      wait_obs(1, 20);
      total++;
      if (obs_q.size() < 1) begin
         bad++;
         $display("FAIL rstmid_resume_timeout: pushes=0 want 1");
         return;
      end
      o = obs_q.pop_front();
      total++;
      if (o.vec !== 4'b0001 || o.data !== exp_q.pop_front()) begin
         bad++;
         $display("FAIL rstmid_resume: vec=%b data=%h want 0001/0cd", o.vec, o.data);
      end
   endtask

`ifdef DEMUX_STATS_EN
   task automatic test_stats();
      obs_t o;
      logic [W-1:0] e;
      int errs;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      clear_logs();
      for (int i = 0; i < 260; i++) send({2'b11, i[7:0]});
      wait_obs(260, 900);
      total++;
      if (obs_q.size() != 260) begin
         bad++;
         $display("FAIL stats_count: pushes=%0d want 260", obs_q.size());
      end
      errs = 0;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         if (o.vec !== 4'b1000 || o.data !== e) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL stats_words: wrong=%0d want 0", errs);
      end
      total++;
      if (cnt3 !== 8'd4 || {cnt2, cnt1, cnt0} !== 24'd0) begin
         bad++;
         $display("FAIL stats_cnt: got %0d %0d %0d %0d want 0 0 0 4", cnt0, cnt1, cnt2, cnt3);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_reset_mid();
`ifdef DEMUX_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
